// File: rtl/sc_ir_fetch.sv
// sc_ir_fetch: instruction fetch sequencer feeding the IR from byte-wide memory
// Reads four big-endian bytes at PC..PC+3, assembles them into one word and
// presents it to the IR for a single LOAD cycle (IRWrite/Done).
// A misaligned PC, or a beat that stalls TIMEOUT_CYCLES cycles, delivers NOP_WORD with Fault.
// Ports:
//   SC_IrFetch_CLOCK_50, SC_IrFetch_Reset_InLow    clock, async active-low reset
//   SC_IrFetch_Start_InHigh, SC_IrFetch_PC_In      fetch request and address
//   SC_IrFetch_MemData_In, SC_IrFetch_MemReady_InHigh   memory byte and its valid flag
//   SC_IrFetch_MemAddr_Out, SC_IrFetch_MemRead_OutHigh  memory byte address and read strobe
//   SC_IrFetch_DataBUS_Out, SC_IrFetch_IRWrite_OutHigh  IR word and IR write pulse
//   SC_IrFetch_Busy_OutHigh, SC_IrFetch_Done_OutHigh, SC_IrFetch_Fault_OutHigh   status
module sc_ir_fetch #(
  parameter int DATAWIDTH_BUS = 32,
  parameter int DATAWIDTH_ADDR = 32,
  parameter int TIMEOUT_CYCLES = 15,
  parameter logic [DATAWIDTH_BUS-1:0] NOP_WORD = 32'h01000000
) (
  input  logic                      SC_IrFetch_CLOCK_50,
  input  logic                      SC_IrFetch_Reset_InLow,
  input  logic                      SC_IrFetch_Start_InHigh,
  input  logic [DATAWIDTH_ADDR-1:0] SC_IrFetch_PC_In,
  input  logic [7:0]                SC_IrFetch_MemData_In,
  input  logic                      SC_IrFetch_MemReady_InHigh,
  output logic [DATAWIDTH_ADDR-1:0] SC_IrFetch_MemAddr_Out,
  output logic                      SC_IrFetch_MemRead_OutHigh,
  output logic [DATAWIDTH_BUS-1:0]  SC_IrFetch_DataBUS_Out,
  output logic                      SC_IrFetch_IRWrite_OutHigh,
  output logic                      SC_IrFetch_Busy_OutHigh,
  output logic                      SC_IrFetch_Done_OutHigh,
  output logic                      SC_IrFetch_Fault_OutHigh
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, READ, LOAD} state_t;
  state_t                    r_state, w_state;
  logic [1:0]                r_beat, w_beat;
  logic [CW-1:0]             r_cnt, w_cnt;
  logic [DATAWIDTH_ADDR-1:0] r_pc, w_pc;
  logic [DATAWIDTH_BUS-1:0]  r_shift, w_shift, r_bus, w_bus;
  logic                      r_fault, w_fault;
  always_ff @(posedge SC_IrFetch_CLOCK_50 or negedge SC_IrFetch_Reset_InLow)
    if (!SC_IrFetch_Reset_InLow) begin
      r_state <= IDLE;
      r_beat  <= '0;
      r_cnt   <= '0;
      r_pc    <= '0;
      r_shift <= '0;
      r_bus   <= '0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state;
      r_beat  <= w_beat;
      r_cnt   <= w_cnt;
      r_pc    <= w_pc;
      r_shift <= w_shift;
      r_bus   <= w_bus;
      r_fault <= w_fault;
    end
  always_comb begin
    w_state = r_state;
    w_beat  = r_beat;
    w_cnt   = r_cnt;
    w_pc    = r_pc;
    w_shift = r_shift;
    w_bus   = r_bus;
    w_fault = r_fault;
    case (r_state)
      IDLE: if (SC_IrFetch_Start_InHigh) begin
        w_pc   = SC_IrFetch_PC_In;
        w_beat = '0;
        w_cnt  = '0;
        if (SC_IrFetch_PC_In[1:0] == 2'b00) w_state = READ;
        else begin
          w_shift = NOP_WORD;
          w_fault = 1'b1;
          w_state = LOAD;
        end
      end
      READ: if (SC_IrFetch_MemReady_InHigh) begin
        // ready beats the timeout when both happen in the same cycle
        w_shift = {r_shift[DATAWIDTH_BUS-9:0], SC_IrFetch_MemData_In};
        w_cnt   = '0;
        if (r_beat == 2'd3) begin
          w_fault = 1'b0;
          w_state = LOAD;
        end else w_beat = r_beat + 2'd1;
      end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
        w_shift = NOP_WORD;
        w_fault = 1'b1;
        w_state = LOAD;
      end else w_cnt = r_cnt + CW'(1);
      LOAD: begin
        w_bus   = r_shift;
        w_state = IDLE;
      end
      default: w_state = IDLE;
    endcase
  end
  // the delivered word is shown straight from the shifter during LOAD, then held
  assign SC_IrFetch_MemAddr_Out     = r_pc + DATAWIDTH_ADDR'(r_beat);
  assign SC_IrFetch_MemRead_OutHigh = r_state == READ;
  assign SC_IrFetch_DataBUS_Out     = r_state == LOAD ? r_shift : r_bus;
  assign SC_IrFetch_IRWrite_OutHigh = r_state == LOAD;
  assign SC_IrFetch_Done_OutHigh    = r_state == LOAD;
  assign SC_IrFetch_Fault_OutHigh   = r_state == LOAD && r_fault;
  assign SC_IrFetch_Busy_OutHigh    = r_state != IDLE;
endmodule

// File: tb/tb_sc_ir_fetch.sv
// tb_sc_ir_fetch: scoreboard bench for sc_ir_fetch with a wait-state memory responder
module tb_sc_ir_fetch;
  localparam logic [31:0] NOP = 32'h01000000;
  localparam logic [31:0] T1W = 32'h82106005;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, mem_rdy, mem_rd, irw, busy, done, fault;
  logic [31:0] pc = '0, mem_addr, data;
  logic [7:0] mem_data;
  logic [7:0] rom [4] = '{8'h82, 8'h10, 8'h60, 8'h05};
  logic mem_en = 1'b1;
  int wait_n = 0, wcnt = 0, pass = 0, total = 0, n_irw = 0;
  logic [32:0] sb [$];
  sc_ir_fetch dut (
    .SC_IrFetch_CLOCK_50(clk), .SC_IrFetch_Reset_InLow(rst_n),
    .SC_IrFetch_Start_InHigh(start), .SC_IrFetch_PC_In(pc),
    .SC_IrFetch_MemData_In(mem_data), .SC_IrFetch_MemReady_InHigh(mem_rdy),
    .SC_IrFetch_MemAddr_Out(mem_addr), .SC_IrFetch_MemRead_OutHigh(mem_rd),
    .SC_IrFetch_DataBUS_Out(data), .SC_IrFetch_IRWrite_OutHigh(irw),
    .SC_IrFetch_Busy_OutHigh(busy), .SC_IrFetch_Done_OutHigh(done),
    .SC_IrFetch_Fault_OutHigh(fault)
  );
  always #5 clk = ~clk;
  assign mem_data = rom[mem_addr[1:0]];
  assign mem_rdy  = mem_en && mem_rd && (wcnt == wait_n);
  always @(posedge clk) wcnt <= (!mem_rd || mem_rdy) ? 0 : wcnt + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  always @(negedge clk) begin
    logic [32:0] e;
    if (irw) begin
      n_irw++;
      if (sb.size() == 0) chk("unexpected_irwrite", 1, 0);
      else begin
        e = sb.pop_front();
        chk("ir_word", data, e[31:0]);
        chk("ir_fault", fault, e[32]);
        chk("ir_done", done, 1);
      end
    end else if (done || fault) chk("done_fault_outside_load", {done, fault}, 0);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic go(input logic [31:0] a);
    pc = a;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic count_read(output int n);
    n = 0;
    while (mem_rd && n < 100) begin
      n++;
      tick();
    end
  endtask
  initial begin
    int n, base;
    #2;
    chk("reset_outputs", {mem_addr, mem_rd, data, irw, busy, done, fault}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    // T1 zero-wait fetch
    sb.push_back({1'b0, T1W});
    go(32'h100);
    for (int b = 0; b < 4; b++) begin
      chk("t1_addr", mem_addr, 32'h100 + b);
      chk("t1_read", {mem_rd, busy}, 2'b11);
      tick();
    end
    chk("t1_load", {irw, busy, mem_rd}, 3'b110);
    tick();
    chk("t1_idle", {busy, irw, data}, {2'b00, T1W});
    // T2 three wait states per beat
    wait_n = 3;
    sb.push_back({1'b0, T1W});
    go(32'h100);
    count_read(n);
    chk("t2_read_cycles", n, 16);
    tick();
    // T3 timeout
    mem_en = 1'b0;
    sb.push_back({1'b1, NOP});
    go(32'h200);
    count_read(n);
    chk("t3_read_cycles", n, 15);
    chk("t3_load", {irw, data}, {1'b1, NOP});
    tick();
    mem_en = 1'b1;
    wait_n = 0;
    // T4 misaligned PC goes straight to LOAD
    sb.push_back({1'b1, NOP});
    go(32'h102);
    chk("t4_load_no_read", {mem_rd, irw, data}, {2'b01, NOP});
    tick();
    chk("t4_idle", {mem_rd, busy}, 0);
    tick();
    // T5 start held high: one fetch per 6 cycles
    base = n_irw;
    repeat (3) sb.push_back({1'b0, T1W});
    pc = 32'h100;
    start = 1'b1;
    repeat (18) tick();
    start = 1'b0;
    repeat (8) tick();
    chk("t5_held_irw", n_irw - base, 3);
    // T5 start pulse during READ is not queued
    base = n_irw;
    sb.push_back({1'b0, T1W});
    go(32'h100);
    pc = 32'h200;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    chk("t5_pulse_ignored", n_irw - base, 1);
    // T6 reset mid-fetch
    base = n_irw;
    go(32'h100);
    tick();
    tick();
    chk("t6_beat2_addr", mem_addr, 32'h102);
    rst_n = 1'b0;
    #1;
    chk("t6_reset_outputs", {mem_addr, mem_rd, data, irw, busy, done, fault}, 0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("t6_no_irw", n_irw - base, 0);
    sb.push_back({1'b0, T1W});
    go(32'h100);
    repeat (5) tick();
    chk("t6_op", data[31:30], 2);
    chk("t6_rd", data[29:25], 1);
    chk("t6_op3", data[24:19], 6'h02);
    chk("t6_rs1", data[18:14], 1);
    chk("t6_bit13", data[13], 1);
    chk("t6_rs2", data[4:0], 5);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
